// File: rtl/fb_port_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_port_a_arbiter
// Purpose  : Shares framebuffer write port A between control writes and a
//            background clear sweep that only uses idle cycles.
// Revision : 1.0
// ============================================================================
module fb_port_a_arbiter #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 12'd4095
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  ctrl_we,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_data,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  input  logic                  clear_abort,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  output logic                  ram_clk_enable,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [7:0]            preempt_count
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_clear = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] w_fill_nxt;
  logic [7:0]            r_pcnt;
  logic [7:0]            w_pcnt_nxt;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_busy;
  logic                  w_done;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic                  r_done;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (clear_start) w_state_nxt = c_st_clear;
      c_st_clear: begin
        // Abort wins over completion when both land in the same cycle.
        if (clear_abort)                               w_state_nxt = c_st_idle;
        else if (!ctrl_we && r_clr_addr == LAST_ADDR)  w_state_nxt = c_st_done;
      end
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_we           = ctrl_we;
    w_addr         = ctrl_we ? ctrl_addr : '0;
    w_data         = ctrl_we ? ctrl_data : '0;
    w_busy         = 1'b0;
    w_done         = 1'b0;
    w_clr_addr_nxt = r_clr_addr;
    w_fill_nxt     = r_fill;
    w_pcnt_nxt     = r_pcnt;
    case (r_state)
      c_st_idle: begin
        if (clear_start) begin
          w_fill_nxt     = clear_value;
          w_clr_addr_nxt = '0;
          w_pcnt_nxt     = 8'd0;
        end
      end
      c_st_clear: begin
        if (!clear_abort) begin
          w_busy = 1'b1;
          if (ctrl_we) begin
            if (r_pcnt != 8'hFF) w_pcnt_nxt = r_pcnt + 8'd1;
          end else begin
            w_we   = 1'b1;
            w_addr = r_clr_addr;
            w_data = r_fill;
            // Hold at the final address so the sweep never wraps.
            if (r_clr_addr != LAST_ADDR) w_clr_addr_nxt = r_clr_addr + 1'b1;
          end
        end
      end
      c_st_done: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_clr_addr <= '0;
      r_fill     <= '0;
      r_pcnt     <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clr_addr <= w_clr_addr_nxt;
      r_fill     <= w_fill_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign ram_address      = r_addr;
  assign ram_data_out     = r_data;
  assign ram_write_enable = r_we;
  assign ram_clk_enable   = r_we;
  assign clear_busy       = r_busy;
  assign clear_done       = r_done;
  assign preempt_count    = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_a_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_port_a_arbiter
// Purpose  : Randomized and directed self-checking bench for the port A arbiter.
// Revision : 1.0
// ============================================================================
module tb_fb_port_a_arbiter;

  localparam logic [11:0] c_last = 12'd15;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic        ctrl_we = 1'b0;
  logic [11:0] ctrl_addr = '0;
  logic [7:0]  ctrl_data = '0;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_value = '0;
  logic        clear_abort = 1'b0;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;
  logic        ram_clk_enable;
  logic        clear_busy;
  logic        clear_done;
  logic [7:0]  preempt_count;

  fb_port_a_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LAST_ADDR(c_last)) u_dut (
    .clk_in(clk_in), .reset(reset),
    .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
    .clear_start(clear_start), .clear_value(clear_value), .clear_abort(clear_abort),
    .ram_address(ram_address), .ram_data_out(ram_data_out),
    .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
    .clear_busy(clear_busy), .clear_done(clear_done), .preempt_count(preempt_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: a sweep is "next address to fill" plus a pending-done flag.
  bit sweeping, done_pending;
  int nxt, fill, pcnt;
  bit e_we, e_busy, e_done;
  int e_addr, e_data;
  int n_wr, n_done;

  task automatic model_reset();
    sweeping = 0; done_pending = 0; nxt = 0; fill = 0; pcnt = 0;
    e_we = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step();
    bit in_done;
    in_done = done_pending;
    done_pending = 0;
    e_done = in_done;
    e_we = ctrl_we; e_addr = ctrl_addr; e_data = ctrl_data;
    e_busy = sweeping && !clear_abort;
    if (sweeping) begin
      if (clear_abort) sweeping = 0;
      else if (ctrl_we) pcnt = (pcnt < 255) ? pcnt + 1 : 255;
      else begin
        e_we = 1; e_addr = nxt; e_data = fill;
        if (nxt == int'(c_last)) begin sweeping = 0; done_pending = 1; end
        else nxt++;
      end
    end else if (!in_done && clear_start) begin
      sweeping = 1; nxt = 0; fill = clear_value; pcnt = 0;
    end
  endtask

  task automatic cyc(input bit we, input int a, input int d, input bit st, input int v, input bit ab);
    ctrl_we = we; ctrl_addr = a[11:0]; ctrl_data = d[7:0];
    clear_start = st; clear_value = v[7:0]; clear_abort = ab;
    @(posedge clk_in);
    model_step();
    #1;
    chk("we", ram_write_enable, e_we);
    chk("clk_en", ram_clk_enable, e_we);
    if (e_we) begin
      chk("addr", ram_address, e_addr);
      chk("data", ram_data_out, e_data);
    end
    chk("busy", clear_busy, e_busy);
    chk("done", clear_done, e_done);
    chk("pcnt", preempt_count, pcnt);
    if (ram_write_enable) n_wr++;
    if (clear_done) n_done++;
    ctrl_we = 0; clear_start = 0; clear_abort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_we"},   ram_write_enable, 0);
    chk({tag, "_ce"},   ram_clk_enable, 0);
    chk({tag, "_addr"}, ram_address, 0);
    chk({tag, "_data"}, ram_data_out, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_pcnt"}, preempt_count, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 zero_outputs("rst");
    @(negedge clk_in) reset = 1'b1;

    // Reset mid-sweep at clr_addr 7
    cyc(0, 0, 0, 1, 8'h77, 0);
    for (int i = 0; i < 30 && nxt != 7; i++) idle(1);
    chk("reached_7", nxt, 7);
    #2 reset = 1'b0;
    #1 zero_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 zero_outputs("rst_hold");
    @(negedge clk_in) reset = 1'b1;
    n_wr = 0;
    cyc(1, 12'h123, 8'hAB, 0, 0, 0);
    chk("post_rst_addr", ram_address, 12'h123);
    chk("post_rst_data", ram_data_out, 8'hAB);
    chk("post_rst_busy", clear_busy, 0);
    idle(2);
    chk("post_rst_writes", n_wr, 1);

    // Idle sweep
    n_wr = 0; n_done = 0;
    cyc(0, 0, 0, 1, 8'h5A, 0);
    idle(20);
    chk("idle_writes", n_wr, 16);
    chk("idle_done_cnt", n_done, 1);
    chk("idle_pcnt", preempt_count, 0);

    // Preemption
    n_wr = 0; n_done = 0;
    cyc(0, 0, 0, 1, 8'hC3, 0);
    idle(4);
    for (int i = 0; i < 3; i++) cyc(1, 12'h040 + i, 8'h10 + i, 0, 0, 0);
    idle(20);
    chk("pre_writes", n_wr, 19);
    chk("pre_pcnt", preempt_count, 3);
    chk("pre_done_cnt", n_done, 1);

    // Abort at clr_addr 9, then restart from 0
    n_done = 0;
    cyc(0, 0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 30 && nxt != 9; i++) idle(1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("abort_busy", clear_busy, 0);
    idle(3);
    chk("abort_done_cnt", n_done, 0);
    cyc(0, 0, 0, 1, 8'h3C, 0);
    idle(1);
    chk("restart_addr", ram_address, 0);
    chk("restart_data", ram_data_out, 8'h3C);
    idle(20);

    // Simultaneous start + ctrl write, then ignored start mid-sweep
    n_wr = 0;
    cyc(1, 12'h200, 8'h11, 1, 8'hE1, 0);
    chk("sim_ctrl_addr", ram_address, 12'h200);
    idle(6);
    cyc(0, 0, 0, 1, 8'h00, 0);
    chk("sim_ignored_addr", ram_address, 6);
    chk("sim_ignored_data", ram_data_out, 8'hE1);
    idle(20);
    chk("sim_writes", n_wr, 17);

    // Saturation
    n_wr = 0; n_done = 0;
    cyc(0, 0, 0, 1, 8'h42, 0);
    idle(5);
    for (int i = 0; i < 300; i++) cyc(1, $urandom_range(0, 4095), $urandom_range(0, 255), 0, 0, 0);
    chk("sat_pcnt", preempt_count, 255);
    idle(20);
    chk("sat_writes", n_wr, 316);
    chk("sat_done_cnt", n_done, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      cyc(($urandom_range(0, 2) == 0), $urandom_range(0, 4095), $urandom_range(0, 255),
          ($urandom_range(0, 19) == 0), $urandom_range(0, 255), ($urandom_range(0, 59) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_port_a_arbiter.md
Name: fb_port_a_arbiter

Overview:
- Owns framebuffer RAM write port A (12-bit address, 8-bit data) and shares it between two writers.
- Writer 1: the UART control module's pixel writes. They have fixed priority and never stall.
- Writer 2: an internal clear engine that sweeps every framebuffer byte with a fill value on command, using only the cycles the control module leaves idle.
- Sits between control_module and multimem port A in the clk_root domain.

Parameters:
- ADDR_WIDTH, 12, framebuffer port A address width.
- DATA_WIDTH, 8, port A data width.
- LAST_ADDR, 12'd4095, final address swept by the clear engine; benches use 12'd15.

Ports:
- clk_in  input  1  clk_root domain clock.
- reset  input  1  asynchronous, active-low reset.
- ctrl_we  input  1  control-module write strobe, one write per high cycle.
- ctrl_addr  input  ADDR_WIDTH  control-module write address.
- ctrl_data  input  DATA_WIDTH  control-module write data.
- clear_start  input  1  single-cycle pulse that starts a sweep.
- clear_value  input  DATA_WIDTH  fill byte, sampled on an accepted clear_start.
- clear_abort  input  1  single-cycle pulse that aborts a sweep.
- ram_address  output  ADDR_WIDTH  to multimem AddressA.
- ram_data_out  output  DATA_WIDTH  to multimem DataInA.
- ram_write_enable  output  1  to multimem WrA.
- ram_clk_enable  output  1  to multimem ClockEnA.
- clear_busy  output  1  high while a sweep is in progress.
- clear_done  output  1  one-cycle pulse when a sweep completes.
- preempt_count  output  8  ctrl cycles that stole a slot from the clear engine during the current or most recent sweep; saturating.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, FSM in IDLE, clear address 0, latched fill byte 0. Release is synchronous to clk_in.
- All RAM-side outputs are registered: a request accepted at edge N drives the RAM signals from edge N to edge N+1. Latency is 1 cycle.
- ram_write_enable and ram_clk_enable are always equal: high exactly in cycles where a write issues.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - ctrl_we=1 → issue ctrl write (ctrl_addr, ctrl_data).
  - clear_start=1 → latch clear_value, clr_addr=0, preempt_count=0, go to CLEAR.
  - clear_start is accepted even if ctrl_we is high in the same cycle; the ctrl write still issues that cycle.
- CLEAR:
  - clear_busy=1.
  - ctrl_we=1 → issue ctrl write. clr_addr holds. preempt_count increments, saturating at 255.
  - ctrl_we=0 → issue write (clr_addr, latched fill), then clr_addr+1.
  - The clear write at clr_addr==LAST_ADDR moves the FSM to DONE.
  - clear_abort=1 → IDLE next cycle. No clear write issues that cycle (a ctrl write still issues), no clear_done, preempt_count holds.
  - clear_abort takes precedence over completion in the same cycle.
  - clear_start while in CLEAR is ignored.
- DONE: lasts one cycle. clear_done=1, clear_busy=0, ctrl writes serviced, then IDLE. clear_start is ignored in DONE.
- clr_addr never wraps. The sweep stops at LAST_ADDR with exactly LAST_ADDR+1 clear writes issued.
- Ordering hazard: a ctrl write to an address not yet swept is overwritten later by the sweep. This is by design; the host waits for clear_done before sending pixel data.
- Throughput: with ctrl_we held continuously high, the sweep stalls indefinitely with no timeout; ctrl writes are never dropped.

Test Plan:
- Reset mid-sweep: LAST_ADDR=15, start sweep, assert reset at clr_addr=7 → all outputs 0 immediately. After release, ctrl_we at 0x123/0xAB → single write 0x123/0xAB one cycle later, clear_busy=0.
- Idle sweep: clear_start with clear_value=0x5A, ctrl_we=0 → 16 consecutive writes, addr 0..15, data 0x5A. clear_done pulses once in the cycle after the addr-15 write. preempt_count=0.
- Preemption: during sweep, ctrl_we high for 3 cycles at 0x040..0x042 → those three ctrl writes appear in order, sweep addresses resume without gaps, total writes 19, preempt_count=3.
- Abort: clear_abort at clr_addr=9 → no write at addr 9, clear_busy low next cycle, no clear_done. A following clear_start restarts from addr 0.
- Simultaneous: clear_start and ctrl_we in the same IDLE cycle → ctrl write issues first, then the sweep starts at addr 0. A clear_start during CLEAR does not reset clr_addr.
- Saturation: ctrl_we held high for 300 cycles mid-sweep → preempt_count=255, no clear writes during that window, sweep completes after release.
